cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between result producers: ALU and LSB by default.
- Each producer result is a value plus a ROB tag. Results are buffered in a per-producer FIFO.
- One result per cycle is granted by round-robin and broadcast on a registered CDB.
- Consumers are the reservation station, LSB and ROB tag-match logic. Rollback flushes all pending results.

---
 rtl/cdb_arbiter_pkg.sv | 18 +
 rtl/cdb_fifo.sv | 62 ++++++
 rtl/cdb_arbiter.sv | 116 +++++++++++
 tb/tb_cdb_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter and its per-producer FIFOs.
package cdb_arbiter_pkg;

    localparam int unsigned TAG_W_DEF = 4;
    localparam int unsigned ROB_DEPTH = 1 << TAG_W_DEF;
    localparam int unsigned RESULT_W  = 32;

    localparam int unsigned NREQ_DEF  = 2;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned SRC_W_DEF = 1;

    localparam int unsigned ALU_IDX   = 0;
    localparam int unsigned LSB_IDX   = 1;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/cdb_fifo.sv
// Per-producer result FIFO: result+tag entries, head visible combinationally, flushable.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [RESULT_W-1:0]     din_result,
    input  logic [TAG_W-1:0]        din_tag,
    output logic [RESULT_W-1:0]     head_result,
    output logic [TAG_W-1:0]        head_tag,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [RESULT_W-1:0] mem_result [DEPTH];
    logic [TAG_W-1:0]    mem_tag    [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= din_result;
            mem_tag[wr_ptr]    <= din_tag;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_result = mem_result[rd_ptr];
    assign head_tag    = mem_tag[rd_ptr];
    assign empty       = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB between buffered result producers.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF,
    parameter int unsigned SRC_W = SRC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     rollback,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*RESULT_W-1:0] req_result,
    input  logic [NREQ*TAG_W-1:0]    req_tag,
    output logic [NREQ-1:0]          req_ready,
    output logic                     cdb_valid,
    output logic [RESULT_W-1:0]      cdb_result,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [SRC_W-1:0]         cdb_src
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [NREQ-1:0]     accept;
    logic [NREQ-1:0]     cand_valid;
    logic [NREQ-1:0]     fifo_empty;
    logic [NREQ-1:0]     push;
    logic [NREQ-1:0]     pop;
    logic [RESULT_W-1:0] head_result [NREQ];
    logic [TAG_W-1:0]    head_tag    [NREQ];
    logic [CNT_W-1:0]    fifo_count  [NREQ];
    logic [RESULT_W-1:0] cand_result [NREQ];
    logic [TAG_W-1:0]    cand_tag    [NREQ];

    logic                grant;
    logic [SRC_W-1:0]    winner;
    logic [SRC_W-1:0]    scan_idx;
    logic [SRC_W-1:0]    rr_ptr;
    logic [SRC_W-1:0]    rr_next;
    logic                advance;
    logic                flush;

    // rollback only acts when the block is not frozen, and beats grant/push
    assign advance = rdy & ~rollback;
    assign flush   = rdy & rollback;

    for (genvar i = 0; i < NREQ; i++) begin : g_prod
        // Ready is from registered occupancy only, never from this cycle's grant
        assign req_ready[i]   = rdy & (fifo_count[i] < CNT_W'(DEPTH));
        assign accept[i]      = req_valid[i] & req_ready[i];
        // Queued head takes priority over the incoming result to keep order
        assign cand_valid[i]  = ~fifo_empty[i] | accept[i];
        assign cand_result[i] = fifo_empty[i] ? req_result[RESULT_W*i +: RESULT_W] : head_result[i];
        assign cand_tag[i]    = fifo_empty[i] ? req_tag[TAG_W*i +: TAG_W] : head_tag[i];
        assign pop[i]         = advance & grant & (winner == SRC_W'(i)) & ~fifo_empty[i];
        // A bypass winner is broadcast directly and never enqueued
        assign push[i]        = advance & accept[i] & ~(grant & (winner == SRC_W'(i)) & fifo_empty[i]);

        cdb_fifo #(
            .DEPTH (DEPTH),
            .TAG_W (TAG_W)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .push        (push[i]),
            .pop         (pop[i]),
            .din_result  (req_result[RESULT_W*i +: RESULT_W]),
            .din_tag     (req_tag[TAG_W*i +: TAG_W]),
            .head_result (head_result[i]),
            .head_tag    (head_tag[i]),
            .empty       (fifo_empty[i]),
            .count       (fifo_count[i])
        );
    end

    // Round-robin scan starting at rr_ptr; first candidate wins
    always_comb begin
        grant    = FALSE;
        winner   = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = SRC_W'((32'(rr_ptr) + k) % NREQ);
            if (!grant && cand_valid[scan_idx]) begin
                grant  = TRUE;
                winner = scan_idx;
            end
        end
        rr_next = SRC_W'((32'(winner) + 32'd1) % NREQ);
    end

    // Registered CDB broadcast and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid  <= 1'b0;
            cdb_result <= '0;
            cdb_tag    <= '0;
            cdb_src    <= '0;
            rr_ptr     <= '0;
        end else if (flush) begin
            cdb_valid  <= 1'b0;
            rr_ptr     <= '0;
        end else if (advance) begin
            cdb_valid  <= grant;
            if (grant) begin
                cdb_result <= cand_result[winner];
                cdb_tag    <= cand_tag[winner];
                cdb_src    <= winner;
                rr_ptr     <= rr_next;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, collision, saturation, rollback, async reset, stall.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic [1:0]  req_valid;
    logic [63:0] req_result;
    logic [7:0]  req_tag;
    logic [1:0]  req_ready;
    logic        cdb_valid;
    logic [31:0] cdb_result;
    logic [3:0]  cdb_tag;
    logic [0:0]  cdb_src;

    int checks = 0;
    int errors = 0;

    logic        last_rdy;
    logic [35:0] got0[$];
    logic [35:0] got1[$];
    logic        got_src[$];

    cdb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .rollback   (rollback),
        .req_valid  (req_valid),
        .req_result (req_result),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .cdb_valid  (cdb_valid),
        .cdb_result (cdb_result),
        .cdb_tag    (cdb_tag),
        .cdb_src    (cdb_src)
    );

    always #5 clk = ~clk;

    // Record every fresh broadcast (an edge with rdy=1 that left cdb_valid high)
    always @(posedge clk) last_rdy = rdy;
    always @(negedge clk) begin
        if (rst === 1'b1 && last_rdy === 1'b1 && cdb_valid === 1'b1) begin
            if (cdb_src == 1'b0) got0.push_back({cdb_tag, cdb_result});
            else                 got1.push_back({cdb_tag, cdb_result});
            got_src.push_back(cdb_src[0]);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

    task automatic drive(input logic [1:0] v, input logic [31:0] r0, input logic [3:0] t0,
                         input logic [31:0] r1, input logic [3:0] t1);
        req_valid  = v;
        req_result = {r1, r0};
        req_tag    = {t1, t0};
    endtask

    task automatic clear_log();
        got0.delete();
        got1.delete();
        got_src.delete();
    endtask

    task automatic do_rollback();
        @(negedge clk);
        drive(2'b00, 0, 0, 0, 0);
        rollback = 1'b1;
        @(negedge clk);
        rollback = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
        drive(2'b00, 0, 0, 0, 0);
        #1;
        checks++;
        if ({cdb_valid, cdb_src, cdb_tag, cdb_result} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b s=%0d t=%0d r=%h want all zero", cdb_valid, cdb_src, cdb_tag, cdb_result);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready: got %b want 11", req_ready);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        drive(2'b01, 32'h0000_1234, 4'd5, 0, 0);
        @(negedge clk);
        drive(2'b00, 0, 0, 0, 0);
        checks++;
        if ({cdb_valid, cdb_src, cdb_tag, cdb_result} !== {1'b1, 1'b0, 4'd5, 32'h0000_1234}) begin
            errors++;
            $display("FAIL single_bcast: got v=%b s=%0d t=%0d r=%h want v=1 s=0 t=5 r=00001234", cdb_valid, cdb_src, cdb_tag, cdb_result);
        end
        @(negedge clk);
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: got cdb_valid=%b want 0", cdb_valid);
        end
    endtask

    task automatic test_collision();
        logic [31:0] ra [2];
        logic [31:0] rb [2];
        ra = '{32'hA, 32'hC};
        rb = '{32'hB, 32'hD};
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            drive(2'b11, ra[p], 4'(2*p + 1), rb[p], 4'(2*p + 2));
            @(negedge clk);
            drive(2'b00, 0, 0, 0, 0);
            checks++;
            if ({cdb_valid, cdb_src, cdb_tag, cdb_result} !== {1'b1, 1'b0, 4'(2*p + 1), ra[p]}) begin
                errors++;
                $display("FAIL collision_first%0d: got v=%b s=%0d t=%0d r=%h want v=1 s=0 t=%0d r=%h",
                         p, cdb_valid, cdb_src, cdb_tag, cdb_result, 2*p + 1, ra[p]);
            end
            @(negedge clk);
            checks++;
            if ({cdb_valid, cdb_src, cdb_tag, cdb_result} !== {1'b1, 1'b1, 4'(2*p + 2), rb[p]}) begin
                errors++;
                $display("FAIL collision_second%0d: got v=%b s=%0d t=%0d r=%h want v=1 s=1 t=%0d r=%h",
                         p, cdb_valid, cdb_src, cdb_tag, cdb_result, 2*p + 2, rb[p]);
            end
            @(negedge clk);
            checks++;
            if (cdb_valid !== 1'b0) begin
                errors++;
                $display("FAIL collision_idle%0d: got cdb_valid=%b want 0", p, cdb_valid);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0]  exp_rdy [12];
        logic [35:0] exp0[$];
        logic [35:0] exp1[$];
        logic [3:0]  exp_src;
        int n0 = 0;
        int n1 = 0;
        int cyc = 0;
        exp_rdy = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
                    2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        exp_src = 4'b1010;
        clear_log();
        while ((n0 < 12 || n1 < 12) && cyc < 60) begin
            @(negedge clk);
            if (cyc < 12) begin
                checks++;
                if (req_ready !== exp_rdy[cyc]) begin
                    errors++;
                    $display("FAIL sat_ready%0d: got %b want %b", cyc, req_ready, exp_rdy[cyc]);
                end
            end
            drive({n1 < 12, n0 < 12}, 32'h100 + 32'(n0), 4'(n0), 32'h200 + 32'(n1), 4'(n1 + 8));
            if (n0 < 12 && req_ready[0]) begin
                exp0.push_back({4'(n0), 32'h100 + 32'(n0)});
                n0++;
            end
            if (n1 < 12 && req_ready[1]) begin
                exp1.push_back({4'(n1 + 8), 32'h200 + 32'(n1)});
                n1++;
            end
            cyc++;
        end
        @(negedge clk);
        drive(2'b00, 0, 0, 0, 0);
        for (int w = 0; w < 40 && !(got0.size() >= 12 && got1.size() >= 12); w++) @(negedge clk);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_src.size() || got_src[i] !== exp_src[i]) begin
                errors++;
                $display("FAIL sat_rotation%0d: got src %b want %b", i,
                         (i < got_src.size()) ? got_src[i] : 1'bx, exp_src[i]);
            end
        end
        checks++;
        if (got0.size() != 12 || got1.size() != 12) begin
            errors++;
            $display("FAIL sat_count: got %0d/%0d broadcasts want 12/12", got0.size(), got1.size());
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (i >= got0.size() || i >= exp0.size() || got0[i] !== exp0[i]) begin
                errors++;
                $display("FAIL sat_order0_%0d: got %h want %h", i,
                         (i < got0.size()) ? got0[i] : 36'hx, (i < exp0.size()) ? exp0[i] : 36'hx);
            end
            checks++;
            if (i >= got1.size() || i >= exp1.size() || got1[i] !== exp1[i]) begin
                errors++;
                $display("FAIL sat_order1_%0d: got %h want %h", i,
                         (i < got1.size()) ? got1[i] : 36'hx, (i < exp1.size()) ? exp1[i] : 36'hx);
            end
        end
    endtask

    task automatic test_rollback();
        do_rollback();
        clear_log();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            drive(2'b11, 32'hA000 + 32'(n), 4'(n), 32'hB000 + 32'(n), 4'(n + 8));
        end
        @(negedge clk);
        drive(2'b01, 32'hA005, 4'd5, 0, 0);
        @(negedge clk);
        checks++;
        if ({cdb_valid, cdb_src, cdb_tag, cdb_result, req_ready} !== {1'b1, 1'b1, 4'd10, 32'hB002, 2'b11}) begin
            errors++;
            $display("FAIL rb_pre: got v=%b s=%0d t=%0d r=%h rdy=%b want v=1 s=1 t=10 r=0000b002 rdy=11",
                     cdb_valid, cdb_src, cdb_tag, cdb_result, req_ready);
        end
        rollback = 1'b1;
        drive(2'b01, 32'hA006, 4'd6, 0, 0);
        @(negedge clk);
        rollback = 1'b0;
        drive(2'b00, 0, 0, 0, 0);
        checks++;
        if ({cdb_valid, req_ready} !== {1'b0, 2'b11}) begin
            errors++;
            $display("FAIL rb_flush: got v=%b rdy=%b want v=0 rdy=11", cdb_valid, req_ready);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (got0.size() != 3 || got1.size() != 3) begin
            errors++;
            $display("FAIL rb_count: got %0d/%0d broadcasts want 3/3", got0.size(), got1.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got0.size() || got0[i] !== {4'(i), 32'hA000 + 32'(i)} ||
                i >= got1.size() || got1[i] !== {4'(i + 8), 32'hB000 + 32'(i)}) begin
                errors++;
                $display("FAIL rb_values%0d: got %h/%h want %h/%h", i,
                         (i < got0.size()) ? got0[i] : 36'hx, (i < got1.size()) ? got1[i] : 36'hx,
                         {4'(i), 32'hA000 + 32'(i)}, {4'(i + 8), 32'hB000 + 32'(i)});
            end
        end
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            drive(2'b11, 32'h300 + 32'(n), 4'(n), 32'h400 + 32'(n), 4'(n + 8));
        end
        @(negedge clk);
        checks++;
        if ({cdb_valid, cdb_result} !== {1'b1, 32'h301}) begin
            errors++;
            $display("FAIL areset_pre: got v=%b r=%h want v=1 r=00000301", cdb_valid, cdb_result);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({cdb_valid, cdb_src, cdb_tag, cdb_result} !== 38'd0) begin
            errors++;
            $display("FAIL areset_async: got v=%b s=%0d t=%0d r=%h want all zero", cdb_valid, cdb_src, cdb_tag, cdb_result);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(2'b00, 0, 0, 0, 0);
        @(negedge clk);
        clear_log();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_leftover: got cdb_valid=%b want 0", cdb_valid);
        end
        test_single();
        checks++;
        if (got0.size() != 1 || got1.size() != 0) begin
            errors++;
            $display("FAIL areset_count: got %0d/%0d broadcasts want 1/0", got0.size(), got1.size());
        end
    endtask

    task automatic test_rdy_stall();
        do_rollback();
        clear_log();
        @(negedge clk); drive(2'b11, 32'h11, 4'd1, 32'h66, 4'd6);
        @(negedge clk); drive(2'b11, 32'h55, 4'd3, 32'h77, 4'd7);
        @(negedge clk); drive(2'b10, 0, 0, 32'h88, 4'd8);
        @(negedge clk);
        checks++;
        if ({cdb_valid, cdb_src, cdb_tag, cdb_result} !== {1'b1, 1'b0, 4'd3, 32'h55}) begin
            errors++;
            $display("FAIL stall_pre: got v=%b s=%0d t=%0d r=%h want v=1 s=0 t=3 r=00000055", cdb_valid, cdb_src, cdb_tag, cdb_result);
        end
        rdy = 1'b0;
        rollback = 1'b1;
        drive(2'b11, 32'hDEAD_0000, 4'd14, 32'hDEAD_0001, 4'd15);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL stall_ready: got %b want 00", req_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({cdb_valid, cdb_src, cdb_tag, cdb_result, req_ready} !== {1'b1, 1'b0, 4'd3, 32'h55, 2'b00}) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b s=%0d t=%0d r=%h rdy=%b want v=1 s=0 t=3 r=00000055 rdy=00",
                         c, cdb_valid, cdb_src, cdb_tag, cdb_result, req_ready);
            end
        end
        rdy = 1'b1;
        rollback = 1'b0;
        drive(2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({cdb_valid, cdb_src, cdb_tag, cdb_result} !== {1'b1, 1'b1, 4'd7, 32'h77}) begin
            errors++;
            $display("FAIL stall_resume0: got v=%b s=%0d t=%0d r=%h want v=1 s=1 t=7 r=00000077", cdb_valid, cdb_src, cdb_tag, cdb_result);
        end
        @(negedge clk);
        checks++;
        if ({cdb_valid, cdb_src, cdb_tag, cdb_result} !== {1'b1, 1'b1, 4'd8, 32'h88}) begin
            errors++;
            $display("FAIL stall_resume1: got v=%b s=%0d t=%0d r=%h want v=1 s=1 t=8 r=00000088", cdb_valid, cdb_src, cdb_tag, cdb_result);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (got0.size() != 2 || got1.size() != 3 ||
            got0[0] !== {4'd1, 32'h11} || got0[1] !== {4'd3, 32'h55} ||
            got1[0] !== {4'd6, 32'h66} || got1[1] !== {4'd7, 32'h77} || got1[2] !== {4'd8, 32'h88}) begin
            errors++;
            $display("FAIL stall_log: got %0d/%0d broadcasts want 2/3 in order 11,55 / 66,77,88", got0.size(), got1.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        do_rollback();
        test_collision();
        test_saturation();
        test_rollback();
        test_async_reset();
        test_rdy_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
